// File: rtl/protobuf_field_encoder.sv
// Single-field protobuf wire-format encoder: varint tag followed by a varint
// or fixed little-endian payload, emitted one byte per handshake.
module protobuf_field_encoder #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned FIELD_W = 29
) (
  input  logic               clock_clk,
  input  logic               reset_reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FIELD_W-1:0] s_field,
  input  logic [2:0]         s_mode,
  input  logic [DATA_W-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic               m_last,
  output logic               busy,
  output logic               err_illegal,
  output logic [31:0]        field_count,
  output logic [31:0]        byte_count
);

  typedef enum logic [1:0] {IDLE, TAG, VALUE} state_t;

  state_t      state_q, state_d;
  logic [31:0] tag_q, tag_d;
  logic [63:0] val_q, val_d;
  logic [2:0]  idx_q, idx_d;
  logic        fixed_q, fixed_d;
  logic        fix64_q, fix64_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] field_count_q, field_count_d;
  logic [31:0] byte_count_q, byte_count_d;

  logic              accept;
  logic [DATA_W-1:0] zz;
  logic [2:0]        wt;
  logic [2:0]        last_idx;

  always_comb begin
    accept   = m_valid_q && m_ready;
    zz       = (s_data << 1) ^ {DATA_W{s_data[DATA_W-1]}};
    last_idx = fix64_q ? 3'd7 : 3'd3;
    case (s_mode)
      3'd3:    wt = 3'd5;
      3'd4:    wt = 3'd1;
      default: wt = 3'd0;
    endcase

    state_d       = state_q;
    tag_d         = tag_q;
    val_d         = val_q;
    idx_d         = idx_q;
    fixed_d       = fixed_q;
    fix64_d       = fix64_q;
    err_d         = 1'b0;
    byte_count_d  = byte_count_q + 32'(accept);
    field_count_d = field_count_q + 32'(accept && m_last_q);

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (s_mode > 3'd4 || s_field == '0) begin
            err_d = 1'b1;
          end else begin
            tag_d   = 32'({s_field, wt});
            fixed_d = (s_mode == 3'd3) || (s_mode == 3'd4);
            fix64_d = (s_mode == 3'd4);
            case (s_mode)
              3'd1:    val_d = 64'($signed(s_data));
              3'd2:    val_d = 64'(zz);
              3'd3:    val_d = 64'(s_data[31:0]);
              default: val_d = 64'(s_data);
            endcase
            state_d = TAG;
          end
        end
      end
      TAG: begin
        if (accept) begin
          tag_d = tag_q >> 7;
          if (tag_q[31:7] == '0) begin
            state_d = VALUE;
            idx_d   = '0;
          end
        end
      end
      VALUE: begin
        if (accept) begin
          if (fixed_q) begin
            val_d = val_q >> 8;
            idx_d = idx_q + 3'd1;
            if (idx_q == last_idx) state_d = IDLE;
          end else begin
            val_d = val_q >> 7;
            if (val_q[63:7] == '0) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output registers are loaded from the next-state values so the byte on
    // the wire always describes the state being entered.
    s_ready_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    m_valid_d = (state_d != IDLE);
    m_data_d  = '0;
    m_last_d  = 1'b0;
    if (state_d == TAG) begin
      m_data_d = {|tag_d[31:7], tag_d[6:0]};
    end else if (state_d == VALUE) begin
      if (fixed_d) begin
        m_data_d = val_d[7:0];
        m_last_d = (idx_d == (fix64_d ? 3'd7 : 3'd3));
      end else begin
        m_data_d = {|val_d[63:7], val_d[6:0]};
        m_last_d = ~|val_d[63:7];
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      val_q         <= '0;
      idx_q         <= '0;
      fixed_q       <= 1'b0;
      fix64_q       <= 1'b0;
      s_ready_q     <= 1'b1;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      field_count_q <= '0;
      byte_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      val_q         <= val_d;
      idx_q         <= idx_d;
      fixed_q       <= fixed_d;
      fix64_q       <= fix64_d;
      s_ready_q     <= s_ready_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      field_count_q <= field_count_d;
      byte_count_q  <= byte_count_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign err_illegal = err_q;
  assign field_count = field_count_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_protobuf_field_encoder.sv
// Bench for protobuf_field_encoder: byte-queue model of the wire format checked
// every cycle, plus literal byte sequences for known encodings.
module tb_protobuf_field_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [28:0] s_field;
  logic [2:0]  s_mode;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic        err_illegal;
  logic [31:0] field_count;
  logic [31:0] byte_count;

  protobuf_field_encoder #(.DATA_W(64), .FIELD_W(29)) dut (
    .clock_clk     (clk),
    .reset_reset_n (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_field       (s_field),
    .s_mode        (s_mode),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .err_illegal   (err_illegal),
    .field_count   (field_count),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0]  exp_q[$];   // {last, byte}
  logic [8:0]  log_q[$];
  logic [7:0]  lit_q[$];
  int unsigned mod_bytes = 0;
  int unsigned mod_fields = 0;
  bit          err_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_varint(input longint unsigned v, input bit final_group);
    longint unsigned r = v;
    do begin
      logic [7:0] b;
      b = 8'(r % 128);
      r = r / 128;
      if (r != 0) b = b + 8'd128;
      exp_q.push_back({final_group && (r == 0), b});
    end while (r != 0);
  endfunction

  function automatic void push_field(input longint unsigned field, input int mode,
                                     input longint unsigned data);
    longint          s;
    longint unsigned v;
    int              wt;
    wt = (mode == 3) ? 5 : (mode == 4) ? 1 : 0;
    push_varint(field * 8 + longint'(wt), 1'b0);
    s = longint'(data);
    case (mode)
      2:       v = (s >= 0) ? longint'(2 * s) : longint'(-2 * s - 1);
      3:       v = data % 64'h1_0000_0000;
      default: v = data;
    endcase
    if (mode >= 3) begin
      int n = (mode == 3) ? 4 : 8;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({i == n - 1, 8'(v % 256)});
        v = v / 256;
      end
    end else begin
      push_varint(v, 1'b1);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mod_bytes  = 0;
      mod_fields = 0;
      err_exp    = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_field_count", field_count, 0);
    end else begin
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("s_ready", s_ready, exp_q.size() == 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("err_illegal", err_illegal, err_exp);
      chk("byte_count", byte_count, mod_bytes);
      chk("field_count", field_count, mod_fields);
      if (m_valid && exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0][7:0]);
        chk("m_last", m_last, exp_q[0][8]);
        if (m_ready) begin
          log_q.push_back({m_last, m_data});
          if (exp_q[0][8]) mod_fields++;
          void'(exp_q.pop_front());
          mod_bytes++;
        end
      end
      err_exp = 1'b0;
      if (s_valid && s_ready) begin
        if (s_mode > 3'd4 || s_field == 0) err_exp = 1'b1;
        else push_field(longint'(s_field), int'(s_mode), s_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [28:0] f, input logic [2:0] md, input logic [63:0] d);
    int n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=s_ready_low required=s_ready_high");
    end
    s_valid = 1'b1;
    s_field = f;
    s_mode  = md;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !s_ready) && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || !s_ready) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=pending=%0d required=pending=0", exp_q.size());
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, log_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < log_q.size(); i++) begin
      chk({name, "_byte"}, log_q[i][7:0], lit_q[i]);
      chk({name, "_last"}, log_q[i][8], i == lit_q.size() - 1);
    end
    log_q.delete();
  endtask

  task automatic run_lit(input string name, input logic [28:0] f, input logic [2:0] md,
                         input logic [63:0] d);
    log_q.delete();
    send(f, md, d);
    wait_done();
    chk_log(name);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_field = '0;
    s_mode  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    #2;
    chk("reset_m_data", m_data, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err_illegal, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    lit_q = '{8'h08, 8'h96, 8'h01};
    run_lit("varint150", 29'd1, 3'd0, 64'd150);
    chk("varint150_fields", field_count, 1);
    chk("varint150_bytes", byte_count, 3);

    lit_q = '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_lit("signed_m1", 29'd2, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    lit_q = '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run_lit("varint_ffffffff", 29'd2, 3'd0, 64'hFFFF_FFFF);
    lit_q = '{8'h18, 8'h03};
    run_lit("zz_m2", 29'd3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    lit_q = '{8'h18, 8'h00};
    run_lit("zz_0", 29'd3, 3'd2, 64'd0);
    lit_q = '{8'h18, 8'h02};
    run_lit("zz_1", 29'd3, 3'd2, 64'd1);
    lit_q = '{8'h85, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    run_lit("fixed32", 29'd16, 3'd3, 64'hDEAD_BEEF_1234_5678);
    lit_q = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    run_lit("fixed64", 29'd1, 3'd4, 64'h0102_0304_0506_0708);
    lit_q = '{8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h80};
    run_lit("maxfield_fixed64", 29'h1FFF_FFFF, 3'd4, 64'h8000_0000_0000_0000);

    // Model-only vectors, sent back to back.
    send(29'd127, 3'd2, 64'h8000_0000_0000_0000);
    send(29'd15,  3'd1, 64'd300);
    send(29'd16,  3'd0, 64'd0);
    send(29'd2047, 3'd3, 64'hFFFF_FFFF);
    send(29'h3FFF, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF);
    wait_done();

    // Backpressure on the second byte, then reset mid-field.
    log_q.delete();
    send(29'd1, 3'd0, 64'd150);
    tick();
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_m_data", m_data, 8'h96);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
    end
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_bytes", byte_count, 0);
    chk("midrst_fields", field_count, 0);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("postrst_s_ready", s_ready, 1);
    tick();

    // Illegal descriptors are dropped with a single-cycle error pulse.
    log_q.delete();
    send(29'd5, 3'd6, 64'd1);
    chk("ill_mode_err", err_illegal, 1);
    chk("ill_mode_s_ready", s_ready, 1);
    tick();
    chk("ill_mode_err_off", err_illegal, 0);
    send(29'd0, 3'd0, 64'd1);
    chk("ill_field_err", err_illegal, 1);
    chk("ill_field_m_valid", m_valid, 0);
    tick();
    chk("ill_field_err_off", err_illegal, 0);
    lit_q = '{8'h38, 8'hAC, 8'h02};
    run_lit("after_illegal", 29'd7, 3'd0, 64'd300);
    chk("after_illegal_fields", field_count, 1);
    chk("after_illegal_bytes", byte_count, 3);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
